// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_unit                                                       |
// | Purpose : Instruction-fetch front end. Owns the PC, issues in-order        |
// |           requests to a variable-latency instruction memory and buffers    |
// |           returned words, tagged with their PC, in a DEPTH-slot prefetch   |
// |           queue that decode drains over valid/ready. A redirect flushes    |
// |           the queue and discards responses still in flight.                |
// | Ports   : clk            - clock, rising edge                              |
// |           rst            - asynchronous reset, active low                  |
// |           imem_req_*     - fetch request (valid/ready/addr), non-sticky    |
// |           imem_rsp_*     - in-order response (valid/data)                  |
// |           redirect_*     - flush and restart at redirect_pc                |
// |           inst_*         - head of prefetch queue to decode (valid/ready)  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  // Inflight/drop get one extra bit: after a redirect the discarded requests
  // still count as in flight while up to DEPTH new ones are issued.
  localparam int c_INF_W = c_CNT_W + 1;

  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]    c_PC_STEP = XLEN'(4);

  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    r_slot_pc     [DEPTH];
  logic [31:0]        r_slot_word   [DEPTH];
  logic [DEPTH-1:0]   r_slot_filled;
  logic [c_PTR_W-1:0] r_alloc_ptr;
  logic [c_PTR_W-1:0] r_fill_ptr;
  logic [c_PTR_W-1:0] r_pop_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_INF_W-1:0] r_inflight;
  logic [c_INF_W-1:0] r_drop;

  logic w_req_fire;
  logic w_rsp_take;
  logic w_pop;
  logic w_unused_pc_lsbs;

  // rst is active low, so gating with it keeps the request low while the
  // core is held in reset and lets the first request go out on release.
  assign imem_req_valid = rst & (r_count < c_FULL) & ~redirect_valid;
  assign imem_req_addr  = r_fetch_pc;

  assign inst_valid = r_slot_filled[r_pop_ptr] & (r_count != '0) & ~redirect_valid;
  assign inst       = r_slot_word[r_pop_ptr];
  assign inst_pc    = r_slot_pc[r_pop_ptr];

  assign w_req_fire = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding cannot be ours; ignore it.
  assign w_rsp_take = imem_rsp_valid & (r_inflight != '0);
  assign w_pop      = inst_valid & inst_ready;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_slot_filled <= '0;
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_pop_ptr     <= '0;
      r_count       <= '0;
      r_inflight    <= '0;
      r_drop        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slot_pc[i]   <= '0;
        r_slot_word[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still outstanding (minus a response landing right now,
      // which is thrown away) must be discarded when it returns.
      r_fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      r_slot_filled <= '0;
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_pop_ptr     <= '0;
      r_count       <= '0;
      r_inflight    <= r_inflight - c_INF_W'(w_rsp_take);
      r_drop        <= r_inflight - c_INF_W'(w_rsp_take);
    end else begin
      // Alloc, fill and pop always touch distinct slots: alloc takes a free
      // slot, fill a pending one, pop a filled one.
      if (w_req_fire) begin
        r_slot_pc[r_alloc_ptr]     <= r_fetch_pc;
        r_slot_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr                <= r_alloc_ptr + 1'b1;
        r_fetch_pc                 <= r_fetch_pc + c_PC_STEP;
      end
      if (w_rsp_take) begin
        if (r_drop != '0) begin
          r_drop <= r_drop - 1'b1;
        end else begin
          r_slot_word[r_fill_ptr]   <= imem_rsp_data;
          r_slot_filled[r_fill_ptr] <= 1'b1;
          r_fill_ptr                <= r_fill_ptr + 1'b1;
        end
      end
      if (w_pop) begin
        r_slot_filled[r_pop_ptr] <= 1'b0;
        r_pop_ptr                <= r_pop_ptr + 1'b1;
      end
      r_count    <= r_count + c_CNT_W'(w_req_fire) - c_CNT_W'(w_pop);
      r_inflight <= r_inflight + c_INF_W'(w_req_fire) - c_INF_W'(w_rsp_take);
    end
  end

endmodule
`default_nettype wire
